// File: rtl/stage_cp_cdb_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_cp_cdb_if
// Description : EX->complete result bundle plus CDB / PRF-write / ROB-complete
//               broadcast outputs of the complete-stage collector.
// Revision    : 1.0  initial release
// ============================================================================
interface stage_cp_cdb_if #(
    parameter int NUM_FU    = 4,
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 5,
    parameter int XLEN      = 32
);
    logic                          squash;
    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_FU*PREG_BITS-1:0]   fu_dest_tag;
    logic [NUM_FU*ROB_BITS-1:0]    fu_rob_idx;
    logic [NUM_FU*XLEN-1:0]        fu_result;
    logic                          cdb_valid;
    logic [PREG_BITS-1:0]          cdb_tag;
    logic                          prf_wr_en;
    logic [PREG_BITS-1:0]          prf_wr_idx;
    logic [XLEN-1:0]               prf_wr_data;
    logic                          rob_cp_en;
    logic [ROB_BITS-1:0]           rob_cp_idx;

    // FU / pipeline-control side
    modport master (
        output squash, fu_valid, fu_dest_tag, fu_rob_idx, fu_result,
        input  fu_ready, cdb_valid, cdb_tag, prf_wr_en, prf_wr_idx, prf_wr_data,
               rob_cp_en, rob_cp_idx
    );

    // Collector side
    modport slave (
        input  squash, fu_valid, fu_dest_tag, fu_rob_idx, fu_result,
        output fu_ready, cdb_valid, cdb_tag, prf_wr_en, prf_wr_idx, prf_wr_data,
               rob_cp_en, rob_cp_idx
    );
endinterface
`default_nettype wire

// File: rtl/stage_cp_cdb.sv
`default_nettype none
// ============================================================================
// Module      : stage_cp_cdb
// Description : Complete-stage collector: one result slot per FU, round-robin
//               pick onto the registered CDB / PRF write / ROB complete ports.
//               Optional macro CDB_BYPASS_EN lets an incoming winner skip its slot.
// Revision    : 1.0  initial release
// ============================================================================
module stage_cp_cdb #(
    parameter int NUM_FU    = 4,
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 5,
    parameter int XLEN      = 32
) (
    input wire            clock,
    input wire            reset,
    stage_cp_cdb_if.slave cp
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    r_occ;
    logic [PREG_BITS-1:0] r_tag  [NUM_FU];
    logic [ROB_BITS-1:0]  r_rob  [NUM_FU];
    logic [XLEN-1:0]      r_data [NUM_FU];
    logic [PTR_W-1:0]     r_rr;

    logic                 r_out_valid;
    logic                 r_out_cp;
    logic [PREG_BITS-1:0] r_out_tag;
    logic [ROB_BITS-1:0]  r_out_rob;
    logic [XLEN-1:0]      r_out_data;

    logic [NUM_FU-1:0]    w_req;
    logic [NUM_FU-1:0]    w_grant;
    logic [NUM_FU-1:0]    w_accept;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic                 w_bypass_win;
    logic [PREG_BITS-1:0] w_src_tag;
    logic [ROB_BITS-1:0]  w_src_rob;
    logic [XLEN-1:0]      w_src_data;

`ifdef CDB_BYPASS_EN
    // occ | (valid & !occ) reduces to occ | valid
    assign w_req        = r_occ | cp.fu_valid;
    assign w_bypass_win = w_found & ~r_occ[w_win];
`else
    assign w_req        = r_occ;
    assign w_bypass_win = 1'b0;
`endif

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(r_rr) + k) % NUM_FU;
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_win   = idx[PTR_W-1:0];
            end
        end
        w_grant[w_win] = w_found;
    end

    always_comb begin
        w_src_tag  = r_tag[w_win];
        w_src_rob  = r_rob[w_win];
        w_src_data = r_data[w_win];
        if (w_bypass_win) begin
            w_src_tag  = cp.fu_dest_tag[int'(w_win)*PREG_BITS +: PREG_BITS];
            w_src_rob  = cp.fu_rob_idx[int'(w_win)*ROB_BITS +: ROB_BITS];
            w_src_data = cp.fu_result[int'(w_win)*XLEN +: XLEN];
        end
    end

    // A granted slot drains this edge, so it may refill in the same cycle
    assign cp.fu_ready = {NUM_FU{~cp.squash}} & (~r_occ | w_grant);
    assign w_accept    = cp.fu_valid & cp.fu_ready;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset) begin
                r_occ[i]  <= 1'b0;
                r_tag[i]  <= '0;
                r_rob[i]  <= '0;
                r_data[i] <= '0;
            end else if (cp.squash) begin
                r_occ[i] <= 1'b0;
            end else if (w_accept[i] && !(w_grant[i] && w_bypass_win)) begin
                r_occ[i]  <= 1'b1;
                r_tag[i]  <= cp.fu_dest_tag[i*PREG_BITS +: PREG_BITS];
                r_rob[i]  <= cp.fu_rob_idx[i*ROB_BITS +: ROB_BITS];
                r_data[i] <= cp.fu_result[i*XLEN +: XLEN];
            end else if (w_grant[i]) begin
                r_occ[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_cp    <= 1'b0;
            r_out_tag   <= '0;
            r_out_rob   <= '0;
            r_out_data  <= '0;
        end else if (cp.squash) begin
            r_out_valid <= 1'b0;
            r_out_cp    <= 1'b0;
        end else if (w_found) begin
            r_rr        <= PTR_W'((int'(w_win) + 1) % NUM_FU);
            // Tag 0 has no destination register but still completes in the ROB
            r_out_valid <= (w_src_tag != '0);
            r_out_cp    <= 1'b1;
            r_out_tag   <= w_src_tag;
            r_out_rob   <= w_src_rob;
            r_out_data  <= w_src_data;
        end else begin
            r_out_valid <= 1'b0;
            r_out_cp    <= 1'b0;
        end
    end

    assign cp.cdb_valid   = r_out_valid;
    assign cp.cdb_tag     = r_out_tag;
    assign cp.prf_wr_en   = r_out_valid;
    assign cp.prf_wr_idx  = r_out_tag;
    assign cp.prf_wr_data = r_out_data;
    assign cp.rob_cp_en   = r_out_cp;
    assign cp.rob_cp_idx  = r_out_rob;
endmodule
`default_nettype wire

// File: tb/tb_stage_cp_cdb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_cp_cdb
// Description : Directed + random bench for stage_cp_cdb against a queue-based
//               reference model; honours CDB_BYPASS_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stage_cp_cdb;
    localparam int N  = 4;
    localparam int PB = 6;
    localparam int RB = 5;
    localparam int XL = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [PB-1:0] tag;
        logic [RB-1:0] rob;
        logic [XL-1:0] data;
    } res_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    stage_cp_cdb_if #(.NUM_FU(N), .PREG_BITS(PB), .ROB_BITS(RB), .XLEN(XL)) cp ();
    stage_cp_cdb #(.NUM_FU(N), .PREG_BITS(PB), .ROB_BITS(RB), .XLEN(XL)) dut (
        .clock (clock),
        .reset (reset),
        .cp    (cp)
    );

    // pending results per FU; head is what the FU presents
    res_t fu_q [N][$];

    // reference model state
    bit   m_occ  [N];
    res_t m_slot [N];
    bit   m_rdy  [N];
    int   m_rr;
    bit   m_cv;
    bit   m_rc;
    res_t m_out;
    int   m_w;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_no = 0;
    int bc_cnt [64];
    int bc_cyc [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_occ[i]  = 1'b0;
            m_slot[i] = '0;
        end
        m_rr  = 0;
        m_cv  = 1'b0;
        m_rc  = 1'b0;
        m_out = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fu_q[i].size() > 0) begin
                cp.fu_valid[i]               = 1'b1;
                cp.fu_dest_tag[i*PB +: PB]   = fu_q[i][0].tag;
                cp.fu_rob_idx[i*RB +: RB]    = fu_q[i][0].rob;
                cp.fu_result[i*XL +: XL]     = fu_q[i][0].data;
            end else begin
                cp.fu_valid[i]               = 1'b0;
                cp.fu_dest_tag[i*PB +: PB]   = '0;
                cp.fu_rob_idx[i*RB +: RB]    = '0;
                cp.fu_result[i*XL +: XL]     = '0;
            end
        end
    endtask

    // One clock: present queue heads, check readiness, advance model and DUT, check outputs
    task automatic cyc();
        bit   acc [N];
        bit   old [N];
        bit   sq;
        res_t src;
        drive();
        #1;
        sq  = cp.squash;
        m_w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_w < 0 && (m_occ[i] || (BYP && fu_q[i].size() > 0))) m_w = i;
        end
        for (int i = 0; i < N; i++) begin
            m_rdy[i] = !sq && (!m_occ[i] || i == m_w);
            acc[i]   = 1'b0;
            chk($sformatf("fu_ready[%0d]", i), 64'(cp.fu_ready[i]), 64'(m_rdy[i]));
        end
        if (reset) begin
            model_reset();
        end else if (sq) begin
            for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
            m_cv = 1'b0;
            m_rc = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                old[i] = m_occ[i];
                acc[i] = (fu_q[i].size() > 0) && m_rdy[i];
            end
            if (m_w >= 0) begin
                src       = old[m_w] ? m_slot[m_w] : fu_q[m_w][0];
                m_out     = src;
                m_cv      = (src.tag != 0);
                m_rc      = 1'b1;
                m_rr      = (m_w + 1) % N;
                m_occ[m_w] = 1'b0;
            end else begin
                m_cv = 1'b0;
                m_rc = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i] && !(BYP && i == m_w && !old[i])) begin
                    m_occ[i]  = 1'b1;
                    m_slot[i] = fu_q[i][0];
                end
            end
        end
        @(posedge clock);
        #1;
        cyc_no++;
        for (int i = 0; i < N; i++) if (acc[i]) void'(fu_q[i].pop_front());
        if (cp.cdb_valid === 1'b1) begin
            bc_cnt[cp.cdb_tag]++;
            bc_cyc[cp.cdb_tag] = cyc_no;
        end
        chk("cdb_valid",   64'(cp.cdb_valid),   64'(m_cv));
        chk("prf_wr_en",   64'(cp.prf_wr_en),   64'(m_cv));
        chk("rob_cp_en",   64'(cp.rob_cp_en),   64'(m_rc));
        chk("cdb_tag",     64'(cp.cdb_tag),     64'(m_out.tag));
        chk("prf_wr_idx",  64'(cp.prf_wr_idx),  64'(m_out.tag));
        chk("prf_wr_data", 64'(cp.prf_wr_data), 64'(m_out.data));
        chk("rob_cp_idx",  64'(cp.rob_cp_idx),  64'(m_out.rob));
    endtask

    task automatic push(input int fu, input int tag, input int rob, input logic [XL-1:0] data);
        res_t r;
        r.tag  = PB'(tag);
        r.rob  = RB'(rob);
        r.data = data;
        fu_q[fu].push_back(r);
    endtask

    task automatic clear_bc();
        for (int t = 0; t < 64; t++) begin
            bc_cnt[t] = 0;
            bc_cyc[t] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        cp.squash      = 1'b0;
        cp.fu_valid    = '0;
        cp.fu_dest_tag = '0;
        cp.fu_rob_idx  = '0;
        cp.fu_result   = '0;
        clear_bc();
        model_reset();
        @(posedge clock);
        #1;

        // reset held: all outputs quiet, every slot ready
        do_reset();
        chk("rst_cdb_valid", 64'(cp.cdb_valid), 64'd0);
        chk("rst_prf_wr_en", 64'(cp.prf_wr_en), 64'd0);
        chk("rst_rob_cp_en", 64'(cp.rob_cp_en), 64'd0);
        chk("rst_fu_ready",  64'(cp.fu_ready),  64'hF);
        cyc();
        chk("post_rst_cdb_valid", 64'(cp.cdb_valid), 64'd0);

        // single result through FU1
        push(1, 33, 4, 32'h5);
        for (int k = 0; k < LAT; k++) cyc();
        chk("single_valid", 64'(cp.cdb_valid),   64'd1);
        chk("single_tag",   64'(cp.cdb_tag),     64'd33);
        chk("single_prf",   64'(cp.prf_wr_data), 64'h5);
        chk("single_rob",   64'(cp.rob_cp_idx),  64'd4);
        cyc();
        chk("single_drop",  64'(cp.cdb_valid), 64'd0);
        chk("single_cpdrop", 64'(cp.rob_cp_en), 64'd0);

        // all four FUs at once from rr_ptr=0
        do_reset();
        for (int i = 0; i < N; i++) push(i, 40 + i, 10 + i, 32'(100 + i));
        for (int k = 0; k < LAT; k++) cyc();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rr_valid_%0d", i), 64'(cp.cdb_valid), 64'd1);
            chk($sformatf("rr_tag_%0d", i),   64'(cp.cdb_tag),   64'(40 + i));
            cyc();
        end
        chk("rr_idle", 64'(cp.cdb_valid), 64'd0);

        // backpressure: FU0 holds 50 then 51 while FU2 streams
        clear_bc();
        push(0, 50, 1, 32'hA50);
        push(0, 51, 2, 32'hA51);
        for (int i = 0; i < 6; i++) push(2, 20 + i, 3 + i, 32'(700 + i));
        for (int k = 0; k < 40 && (fu_q[0].size() + fu_q[2].size()) > 0; k++) cyc();
        chk("bp_drained", 64'(fu_q[0].size() + fu_q[2].size()), 64'd0);
        for (int k = 0; k < 4; k++) cyc();
        chk("bp_50_once", 64'(bc_cnt[50]), 64'd1);
        chk("bp_51_once", 64'(bc_cnt[51]), 64'd1);
        chk("bp_gap_ok",  64'((bc_cyc[51] - bc_cyc[50]) inside {[1:4]}), 64'd1);

        // tag 0: completes in ROB only
        push(3, 0, 7, 32'hDEAD);
        for (int k = 0; k < LAT; k++) cyc();
        chk("tag0_cp_en",  64'(cp.rob_cp_en),  64'd1);
        chk("tag0_cp_idx", 64'(cp.rob_cp_idx), 64'd7);
        chk("tag0_cdb",    64'(cp.cdb_valid),  64'd0);
        chk("tag0_prf",    64'(cp.prf_wr_en),  64'd0);
        cyc();

        // squash with three slots busy
        push(0, 61, 1, 32'h61);
        push(1, 62, 2, 32'h62);
        push(2, 63, 3, 32'h63);
        cyc();
        cp.squash = 1'b1;
        cyc();
        cp.squash = 1'b0;
        #1;
        chk("sq_cdb_valid", 64'(cp.cdb_valid), 64'd0);
        chk("sq_rob_cp_en", 64'(cp.rob_cp_en), 64'd0);
        chk("sq_fu_ready",  64'(cp.fu_ready),  64'hF);
        push(1, 60, 9, 32'h60);
        for (int k = 0; k < LAT; k++) cyc();
        chk("sq_next_valid", 64'(cp.cdb_valid), 64'd1);
        chk("sq_next_tag",   64'(cp.cdb_tag),   64'd60);
        cyc();

        // random traffic with occasional squash and reset
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 35 && fu_q[i].size() < 3)
                    push(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                         int'($urandom_range(0, 31)), 32'($urandom));
            end
            cp.squash = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            cyc();
        end
        cp.squash = 1'b0;
        reset     = 1'b0;
        for (int k = 0; k < 100 && (fu_q[0].size() + fu_q[1].size() + fu_q[2].size() + fu_q[3].size()) > 0; k++) cyc();
        for (int k = 0; k < 6; k++) cyc();
        chk("final_idle_valid", 64'(cp.cdb_valid), 64'd0);
        chk("final_ready",      64'(cp.fu_ready),  64'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
